// File: rtl/mssd_pkg.sv
// Shared types and widths for the MSSD serial frame transmitter.
// Optional parity bit after the payload is enabled by defining MSSD_TX_PARITY_EN.
package mssd_pkg;

  localparam int unsigned PORT_W   = 2;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned DATA_W   = 15;
  localparam int unsigned GAP_BITS = 2;

  localparam int unsigned CNT_W    = $clog2(DATA_W + 1);
  localparam int unsigned GAP_W    = $clog2(GAP_BITS + 1);
  localparam int unsigned HDR_BITS = 1 + PORT_W + LEN_W;

`ifdef MSSD_TX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StPort,
    StLen,
    StData,
    StParity,
    StGap
  } tx_state_e;

  // Total line cycles from START through the last GAP cycle for an N-bit payload.
  function automatic int unsigned frame_cycles(input int unsigned n);
    return HDR_BITS + n + PAR_BITS + GAP_BITS;
  endfunction

endpackage

// File: rtl/mssd_frame_tx_if.sv
// Request/status bundle between a frame source and the MSSD transmitter.
interface mssd_frame_tx_if;
  import mssd_pkg::*;

  logic              startIn;
  logic [PORT_W-1:0] portIn;
  logic [LEN_W-1:0]  lenIn;
  logic [DATA_W-1:0] dataIn;
  logic              serOut;
  logic              ready;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output startIn, portIn, lenIn, dataIn,
    input  serOut, ready, busy, done, error
  );

  modport slave (
    input  startIn, portIn, lenIn, dataIn,
    output serOut, ready, busy, done, error
  );

endinterface

// File: rtl/mssd_tx_shifter.sv
// Left-aligned MSB-first shift register with a pending-bit counter; a load may be
// combined with a shift so the first bit of a new field leaves in the same cycle.
module mssd_tx_shifter
  import mssd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [CNT_W-1:0]  ld_cnt_i,
  output logic              bit_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [DATA_W-1:0] sh_q, sh_d, src;
  logic [CNT_W-1:0]  cnt_q, cnt_d, src_cnt;

  always_comb begin
    src     = load_i ? ld_data_i : sh_q;
    src_cnt = load_i ? ld_cnt_i : cnt_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    if (shift_i) begin
      sh_d  = {src[DATA_W-2:0], 1'b0};
      cnt_d = src_cnt - 1'b1;
    end else if (load_i) begin
      sh_d  = src;
      cnt_d = src_cnt;
    end
  end

  assign bit_o = src[DATA_W-1];
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mssd_frame_tx.sv
// MSSD serial frame transmitter: start | port | len | payload | gap, MSB first.
// Defining MSSD_TX_PARITY_EN inserts an even-parity bit between payload and gap.
module mssd_frame_tx
  import mssd_pkg::*;
(
  input logic             clk,
  input logic             rst,
  mssd_frame_tx_if.slave  tx
);

  tx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              ser_q, ser_d, ready_q, ready_d, busy_q, busy_d;
  logic              done_q, done_d, error_q, error_d;
`ifdef MSSD_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              sh_load, sh_shift, sh_bit;
  logic [DATA_W-1:0] ld_data;
  logic [CNT_W-1:0]  ld_cnt, sh_cnt, shamt;

  mssd_tx_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (sh_load),
    .shift_i   (sh_shift),
    .ld_data_i (ld_data),
    .ld_cnt_i  (ld_cnt),
    .bit_o     (sh_bit),
    .cnt_o     (sh_cnt)
  );

  // Payload is stored left-aligned so only its N live bits ever reach the line.
  assign shamt = CNT_W'(DATA_W) - CNT_W'(tx.lenIn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      data_q  <= '0;
      gap_q   <= '0;
      ser_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef MSSD_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      ser_q   <= ser_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef MSSD_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    data_d   = data_q;
    gap_d    = gap_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    ld_data  = '0;
    ld_cnt   = '0;
    case (state_q)
      StIdle: begin
        if (tx.startIn && (tx.lenIn != '0)) begin
          state_d = StStart;
          len_d   = tx.lenIn;
          data_d  = tx.dataIn << shamt;
          sh_load = 1'b1;
          ld_data = {tx.portIn, {(DATA_W - PORT_W){1'b0}}};
          ld_cnt  = CNT_W'(PORT_W);
        end
      end
      StStart: begin
        sh_shift = 1'b1;
        state_d  = StPort;
      end
      StPort: begin
        sh_shift = 1'b1;
        if (sh_cnt == '0) begin
          sh_load = 1'b1;
          ld_data = {len_q, {(DATA_W - LEN_W){1'b0}}};
          ld_cnt  = CNT_W'(LEN_W);
          state_d = StLen;
        end
      end
      StLen: begin
        sh_shift = 1'b1;
        if (sh_cnt == '0) begin
          sh_load = 1'b1;
          ld_data = data_q;
          ld_cnt  = CNT_W'(len_q);
          state_d = StData;
        end
      end
      StData: begin
        if (sh_cnt != '0) begin
          sh_shift = 1'b1;
        end else begin
`ifdef MSSD_TX_PARITY_EN
          state_d = StParity;
`else
          state_d = StGap;
          gap_d   = GAP_W'(GAP_BITS - 1);
`endif
        end
      end
`ifdef MSSD_TX_PARITY_EN
      StParity: begin
        state_d = StGap;
        gap_d   = GAP_W'(GAP_BITS - 1);
      end
`endif
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef MSSD_TX_PARITY_EN
  // Running XOR of every field bit that has left the shifter.
  always_comb begin
    par_d = par_q;
    if (state_q == StIdle)  par_d = 1'b0;
    else if (sh_shift)      par_d = par_q ^ sh_bit;
  end
`endif

  always_comb begin
    case (state_d)
      StStart:               ser_d = 1'b0;
      StPort, StLen, StData: ser_d = sh_bit;
`ifdef MSSD_TX_PARITY_EN
      StParity:              ser_d = par_q;
`endif
      default:               ser_d = 1'b1;
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = ~ready_d;
    done_d  = (state_d == StGap) && (gap_d == '0);
    error_d = (state_q == StIdle) && tx.startIn && (tx.lenIn == '0);
  end

  assign tx.serOut = ser_q;
  assign tx.ready  = ready_q;
  assign tx.busy   = busy_q;
  assign tx.done   = done_q;
  assign tx.error  = error_q;

endmodule

// File: tb/tb_mssd_frame_tx.sv
// Directed bench for mssd_frame_tx; expectations follow MSSD_TX_PARITY_EN when defined.
module tb_mssd_frame_tx;
  import mssd_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mssd_frame_tx_if tx ();

  mssd_frame_tx dut (
    .clk (clk),
    .rst (rst),
    .tx  (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, then record the line until ready returns (bounded).
  task automatic run_frame(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d,
                           input int perturb, output logic [31:0] bits, output int nb,
                           output int busy_n, output int done_n, output int done_at,
                           output int bad_n);
    int k;
    bits = '0; busy_n = 0; done_n = 0; done_at = -1; bad_n = 0;
    tx.startIn = 1'b1; tx.portIn = p; tx.lenIn = l; tx.dataIn = d;
    @(posedge clk); #1;
    tx.startIn = 1'b0;
    k = 0;
    while (!tx.ready && k < 64) begin
      bits = {bits[30:0], tx.serOut};
      if (tx.busy) busy_n++;
      if (tx.done) begin
        done_n++;
        done_at = k;
      end
      if ((tx.ready === tx.busy) || tx.error) bad_n++;
      if (k == perturb) begin
        tx.startIn = 1'b1; tx.portIn = ~p; tx.lenIn = 4'hF; tx.dataIn = 15'h0000;
      end
      if (k == perturb + 1) tx.startIn = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    tx.startIn = 1'b0;
    nb = k;
  endtask

  logic [31:0] bits;
  int nb, busy_n, done_n, done_at, bad_n, dn;

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    tx.startIn = 1'b0; tx.portIn = '0; tx.lenIn = '0; tx.dataIn = '0;
    #12;
    chk("rst_ser",   tx.serOut, 32'd1);
    chk("rst_ready", tx.ready,  32'd1);
    chk("rst_busy",  tx.busy,   32'd0);
    chk("rst_done",  tx.done,   32'd0);
    chk("rst_error", tx.error,  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-length request is dropped with a one-cycle error pulse.
    tx.startIn = 1'b1; tx.portIn = 2'b10; tx.lenIn = 4'd0; tx.dataIn = 15'h7FFF;
    @(posedge clk); #1;
    tx.startIn = 1'b0;
    chk("len0_error", tx.error,  32'd1);
    chk("len0_ser",   tx.serOut, 32'd1);
    chk("len0_ready", tx.ready,  32'd1);
    chk("len0_busy",  tx.busy,   32'd0);
    @(posedge clk); #1;
    chk("len0_error_clr", tx.error, 32'd0);

    // port=11 len=3 data=101
    run_frame(2'b11, 4'd3, 15'b101, -10, bits, nb, busy_n, done_n, done_at, bad_n);
`ifdef MSSD_TX_PARITY_EN
    chk("f2_bits", bits, {19'd0, 1'b0, 2'b11, 4'b0011, 3'b101, 1'b0, 2'b11});
    chk("f2_len", nb, 32'd13);
    chk("f2_busy", busy_n, 32'd13);
    chk("f2_done_at", done_at, 32'd12);
`else
    chk("f2_bits", bits, {20'd0, 1'b0, 2'b11, 4'b0011, 3'b101, 2'b11});
    chk("f2_len", nb, 32'd12);
    chk("f2_busy", busy_n, 32'd12);
    chk("f2_done_at", done_at, 32'd11);
`endif
    chk("f2_done_n", done_n, 32'd1);
    chk("f2_excl", bad_n, 32'd0);

    // Back-to-back: maximum length, port=10 len=15 data=5AA5
    run_frame(2'b10, 4'd15, 15'h5AA5, -10, bits, nb, busy_n, done_n, done_at, bad_n);
`ifdef MSSD_TX_PARITY_EN
    chk("f4_bits", bits, {7'd0, 1'b0, 2'b10, 4'b1111, 15'h5AA5, 1'b1, 2'b11});
    chk("f4_len", nb, 32'd25);
    chk("f4_busy", busy_n, 32'd25);
    chk("f4_done_at", done_at, 32'd24);
`else
    chk("f4_bits", bits, {8'd0, 1'b0, 2'b10, 4'b1111, 15'h5AA5, 2'b11});
    chk("f4_len", nb, 32'd24);
    chk("f4_busy", busy_n, 32'd24);
    chk("f4_done_at", done_at, 32'd23);
`endif
    chk("f4_done_n", done_n, 32'd1);
    chk("f4_excl", bad_n, 32'd0);

    // startIn and new fields during DATA must not disturb the frame; high junk bits masked
    run_frame(2'b01, 4'd5, 15'h7FF6, 8, bits, nb, busy_n, done_n, done_at, bad_n);
`ifdef MSSD_TX_PARITY_EN
    chk("f5_bits", bits, {17'd0, 1'b0, 2'b01, 4'b0101, 5'b10110, 1'b0, 2'b11});
    chk("f5_len", nb, 32'd15);
`else
    chk("f5_bits", bits, {18'd0, 1'b0, 2'b01, 4'b0101, 5'b10110, 2'b11});
    chk("f5_len", nb, 32'd14);
`endif
    chk("f5_done_n", done_n, 32'd1);
    chk("f5_excl", bad_n, 32'd0);
    @(posedge clk); #1;
    chk("f5_no_requeue", tx.ready, 32'd1);

    // Minimum length: port=01 len=1 data=1
    run_frame(2'b01, 4'd1, 15'h0001, -10, bits, nb, busy_n, done_n, done_at, bad_n);
`ifdef MSSD_TX_PARITY_EN
    chk("f6_bits", bits, {21'd0, 1'b0, 2'b01, 4'b0001, 1'b1, 1'b1, 2'b11});
    chk("f6_len", nb, 32'd11);
    chk("f6_done_at", done_at, 32'd10);
`else
    chk("f6_bits", bits, {22'd0, 1'b0, 2'b01, 4'b0001, 1'b1, 2'b11});
    chk("f6_len", nb, 32'd10);
    chk("f6_done_at", done_at, 32'd9);
`endif

    // Reset in the middle of an all-zero payload
    tx.startIn = 1'b1; tx.portIn = 2'b01; tx.lenIn = 4'd8; tx.dataIn = '0;
    @(posedge clk); #1;
    tx.startIn = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rmid_pre_ser",  tx.serOut, 32'd0);
    chk("rmid_pre_busy", tx.busy,   32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmid_ser",   tx.serOut, 32'd1);
    chk("rmid_ready", tx.ready,  32'd1);
    chk("rmid_busy",  tx.busy,   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (tx.done || !tx.serOut) dn++;
    end
    chk("rmid_no_done", dn, 32'd0);
    chk("rmid_ready_after", tx.ready, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
